// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the data memory (slave).
interface mem_stage_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  dmem_req;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_be;
    logic [31:0]           dmem_wdata;
    logic                  dmem_ack;
    logic [31:0]           dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores on a req/ack bus, stalls earlier stages, holds the M->W register.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses skip the bus and are flagged on MisalignW.
module mem_stage #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    output logic        StallM,
    mem_stage_if.master dmem,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ResultW,
`ifdef MISALIGN_TRAP_EN
    output logic        MisalignW,
`endif
    output logic        BusErrW
);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d, we_q, we_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d, hold_q, hold_d;
    logic [2:0]            fn3_q, fn3_d;
    logic [1:0]            off_q, off_d;

    logic                  reg_write_w_q, reg_write_w_d, bus_err_w_q, bus_err_w_d;
    logic [1:0]            result_src_w_q, result_src_w_d;
    logic [31:0]           alu_result_w_q, alu_result_w_d, read_data_w_q, read_data_w_d;
    logic [31:0]           pc_plus4_w_q, pc_plus4_w_d;
    logic [4:0]            rd_w_q, rd_w_d;

    logic        mem_op_c, issue_c, stall_c, sign_c;
    logic [1:0]  offset_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign mem_op_c = MemWriteM | (ResultSrcM == 2'b01);
    assign offset_c = ALUResultM[1:0];
    assign stall_c  = ((state_q == IDLE) && mem_op_c) || (state_q == REQ);

`ifdef MISALIGN_TRAP_EN
    logic misalign_c, mis_q, mis_d, mis_w_q, mis_w_d;
    assign misalign_c = ((Funct3M[1:0] == 2'b01) && offset_c[0]) ||
                        (Funct3M[1] && (offset_c != 2'b00));
    assign issue_c    = mem_op_c & ~misalign_c;
`else
    assign issue_c    = mem_op_c;
`endif

    // Lane enables and replicated store data; misaligned H/W fall back to the aligned lanes.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                be_c    = 4'b0001 << offset_c;
                wdata_c = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_c    = offset_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_c = 8'(dmem.dmem_rdata >> {off_q, 3'b000});
    assign half_c = 16'(dmem.dmem_rdata >> {off_q[1], 4'b0000});
    assign sign_c = ~fn3_q[2];

    always_comb begin
        load_c = dmem.dmem_rdata;
        case (fn3_q[1:0])
            2'b00:   load_c = {{24{sign_c & byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{sign_c & half_c[15]}}, half_c};
            default: ;
        endcase
    end

    // Access sequencing and bus register next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        fn3_d   = fn3_q;
        off_d   = off_q;
        hold_d  = hold_q;
        err_d   = err_q;
`ifdef MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    hold_d  = '0;
                    err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    mis_d   = misalign_c;
`endif
                    if (issue_c) begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        fn3_d   = Funct3M;
                        off_d   = offset_c;
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) hold_d = load_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // M->W register: bubble while stalled, completed access data in DONE.
    always_comb begin
        reg_write_w_d  = reg_write_w_q;
        result_src_w_d = result_src_w_q;
        alu_result_w_d = alu_result_w_q;
        read_data_w_d  = read_data_w_q;
        rd_w_d         = rd_w_q;
        pc_plus4_w_d   = pc_plus4_w_q;
        bus_err_w_d    = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis_w_d        = 1'b0;
`endif
        if (stall_c) begin
            reg_write_w_d = 1'b0;
        end else begin
            reg_write_w_d  = RegWriteM;
            result_src_w_d = ResultSrcM;
            alu_result_w_d = ALUResultM;
            rd_w_d         = RdM;
            pc_plus4_w_d   = PCPlus4M;
            if (state_q == DONE) begin
                read_data_w_d = hold_q;
                bus_err_w_d   = err_q;
`ifdef MISALIGN_TRAP_EN
                mis_w_d       = mis_q;
                reg_write_w_d = RegWriteM & ~mis_q;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            fn3_q          <= '0;
            off_q          <= '0;
            hold_q         <= '0;
            err_q          <= 1'b0;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= '0;
            alu_result_w_q <= '0;
            read_data_w_q  <= '0;
            rd_w_q         <= '0;
            pc_plus4_w_q   <= '0;
            bus_err_w_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q          <= 1'b0;
            mis_w_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            fn3_q          <= fn3_d;
            off_q          <= off_d;
            hold_q         <= hold_d;
            err_q          <= err_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
            rd_w_q         <= rd_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            bus_err_w_q    <= bus_err_w_d;
`ifdef MISALIGN_TRAP_EN
            mis_q          <= mis_d;
            mis_w_q        <= mis_w_d;
`endif
        end
    end

    // Reset must release the upstream stages at once, even mid-access.
    assign StallM          = stall_c & ~rst;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign RegWriteW       = reg_write_w_q;
    assign ResultSrcW      = result_src_w_q;
    assign ALUResultW      = alu_result_w_q;
    assign ReadDataW       = read_data_w_q;
    assign RdW             = rd_w_q;
    assign PCPlus4W        = pc_plus4_w_q;
    assign BusErrW         = bus_err_w_q;
`ifdef MISALIGN_TRAP_EN
    assign MisalignW       = mis_w_q;
`endif

    always_comb begin
        case (result_src_w_q)
            2'b01:   ResultW = read_data_w_q;
            2'b10:   ResultW = pc_plus4_w_q;
            default: ResultW = alu_result_w_q;
        endcase
    end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;
    localparam int unsigned MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        StallM, RegWriteW, BusErrW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ResultW;
    logic [4:0]  RdW;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the instruction currently visible in W
    logic        exp_rw, exp_berr, exp_mis;
    logic [1:0]  exp_rs;
    logic [31:0] exp_alu, exp_rdw, exp_pc;
    logic [4:0]  exp_rd;

    mem_stage_if #(.ADDR_WIDTH(32)) bus ();

    mem_stage #(.ADDR_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RdM(RdM), .PCPlus4M(PCPlus4M), .StallM(StallM), .dmem(bus.master),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .ResultW(ResultW),
`ifdef MISALIGN_TRAP_EN
        .MisalignW(MisalignW),
`endif
        .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_result();
        case (exp_rs)
            2'b01:   return exp_rdw;
            2'b10:   return exp_pc;
            default: return exp_alu;
        endcase
    endfunction

    task automatic check_w(input string tag);
        check({tag, "_regwrite"}, 32'(RegWriteW), 32'(exp_rw));
        check({tag, "_rd"},       32'(RdW),       32'(exp_rd));
        check({tag, "_rsrc"},     32'(ResultSrcW), 32'(exp_rs));
        check({tag, "_alu"},      ALUResultW,     exp_alu);
        check({tag, "_rdata"},    ReadDataW,      exp_rdw);
        check({tag, "_pc4"},      PCPlus4W,       exp_pc);
        check({tag, "_buserr"},   32'(BusErrW),   32'(exp_berr));
        check({tag, "_result"},   ResultW,        model_result());
`ifdef MISALIGN_TRAP_EN
        check({tag, "_misalign"}, 32'(MisalignW), 32'(exp_mis));
`endif
    endtask

    function automatic logic [31:0] m_be(input logic [2:0] f3, input int unsigned off);
        if (f3[1:0] == 2'b00) return 32'(1) << off;
        if (f3[1:0] == 2'b01) return 32'(3) << (2 * (off / 2));
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3[1:0] == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input int unsigned off,
                                           input logic [31:0] rd);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'b01) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input int unsigned off);
        if (f3[1:0] == 2'b01) return (off % 2) != 0;
        if (f3[1:0] == 2'b10) return off != 0;
        return 1'b0;
    endfunction

    // Present one instruction in M, play the memory side, and check every cycle until it lands in W.
    task automatic do_op(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] rd, input int wait_n, input logic [31:0] rdata);
        bit is_mem, trap, timeout;
        int unsigned off;
        is_mem = mw || (rs == 2'b01);
        off = int'(alu[1:0]);
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = is_mem && m_misaligned(f3, off);
`endif
        RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw; Funct3M = f3;
        ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc; RdM = rd;
        bus.dmem_ack = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom();
        #1;
        check("stall_first", 32'(StallM), 32'(is_mem));
        @(posedge clk); #1;
        if (!is_mem) begin
            bus.dmem_ack = 1'b0;
            check("alu_no_req", 32'(bus.dmem_req), 32'd0);
            exp_rw = rw; exp_rs = rs; exp_alu = alu; exp_rd = rd; exp_pc = pc;
            exp_berr = 1'b0; exp_mis = 1'b0;
            check_w("alu");
            return;
        end
        exp_rw = 1'b0; exp_berr = 1'b0; exp_mis = 1'b0;
        check_w("bubble_issue");
        timeout = !trap;
        if (!trap) begin
            for (int i = 0; i < int'(MAX_WAIT); i++) begin
                check("req_stall", 32'(StallM), 32'd1);
                check("req_valid", 32'(bus.dmem_req), 32'd1);
                check("req_we",    32'(bus.dmem_we), 32'(mw));
                check("req_addr",  bus.dmem_addr, alu & 32'hFFFF_FFFC);
                check("req_be",    32'(bus.dmem_be), m_be(f3, off));
                check("req_wdata", bus.dmem_wdata, m_wdata(f3, wd));
                bus.dmem_ack = (i == wait_n);
                bus.dmem_rdata = (i == wait_n) ? rdata : $urandom();
                @(posedge clk); #1;
                bus.dmem_ack = 1'b0;
                check_w("bubble_req");
                if (i == wait_n) begin
                    timeout = 1'b0;
                    break;
                end
            end
        end
        check("done_stall", 32'(StallM), 32'd0);
        check("done_req",   32'(bus.dmem_req), 32'd0);
        if (!trap) check("done_be", 32'(bus.dmem_be), m_be(f3, off));
        bus.dmem_ack = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom();
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        exp_rw = trap ? 1'b0 : rw;
        exp_rs = rs; exp_alu = alu; exp_rd = rd; exp_pc = pc;
        exp_rdw = (!mw && !timeout && !trap) ? m_load(f3, off, rdata) : 32'd0;
        exp_berr = timeout;
        exp_mis = trap;
        check_w("mem");
    endtask

    initial begin
        int unsigned kind, r, wn;
        logic [2:0] f3;
        logic [1:0] rs;
        int f3_ld[5] = '{0, 1, 2, 4, 5};

        rst = 1'b1;
        RegWriteM = 1'b0; ResultSrcM = 2'b00; MemWriteM = 1'b0; Funct3M = 3'b000;
        ALUResultM = '0; WriteDataM = '0; PCPlus4M = '0; RdM = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        exp_rw = 1'b0; exp_berr = 1'b0; exp_mis = 1'b0; exp_rs = '0;
        exp_alu = '0; exp_rdw = '0; exp_pc = '0; exp_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(StallM), 32'd0);
        check("rst_req",   32'(bus.dmem_req), 32'd0);
        check("rst_we",    32'(bus.dmem_we), 32'd0);
        check("rst_be",    32'(bus.dmem_be), 32'd0);
        check("rst_addr",  bus.dmem_addr, 32'd0);
        check("rst_wdata", bus.dmem_wdata, 32'd0);
        check_w("rst");
        rst = 1'b0;

        do_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h40, 5'd5, 0, 32'h0);
        check("alu_rd5", 32'(RdW), 32'd5);
        check("alu_result", ResultW, 32'h1234);

        do_op(1'b1, 2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 32'h44, 5'd7, 0, 32'h80AA_BBCC);
        check("lb_result", ResultW, 32'hFFFF_FF80);

        do_op(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 32'h48, 5'd0, 3, 32'h0);

        do_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 32'h4C, 5'd9, 100, 32'h0);
        check("timeout_buserr", 32'(BusErrW), 32'd1);
        do_op(1'b1, 2'b10, 1'b0, 3'b000, 32'h55, 32'h0, 32'h50, 5'd3, 0, 32'h0);

        // Reset while a load is waiting for ack
        RegWriteM = 1'b1; ResultSrcM = 2'b01; MemWriteM = 1'b0; Funct3M = 3'b010;
        ALUResultM = 32'h200; RdM = 5'd4; PCPlus4M = 32'h60;
        @(posedge clk); #1;
        check("midrst_req_before", 32'(bus.dmem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_req",   32'(bus.dmem_req), 32'd0);
        check("midrst_stall", 32'(StallM), 32'd0);
        check("midrst_be",    32'(bus.dmem_be), 32'd0);
        exp_rw = 1'b0; exp_berr = 1'b0; exp_mis = 1'b0; exp_rs = '0;
        exp_alu = '0; exp_rdw = '0; exp_pc = '0; exp_rd = '0;
        check_w("midrst");
        ResultSrcM = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h64, 5'd5, 0, 32'h0);

`ifdef MISALIGN_TRAP_EN
        do_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h101, 32'h0, 32'h68, 5'd6, 0, 32'h0);
        check("trap_misalign", 32'(MisalignW), 32'd1);
        check("trap_regwrite", 32'(RegWriteW), 32'd0);
`endif

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            wn = (r == 9) ? MAX_WAIT + 3 : $urandom_range(0, 4);
            case (kind)
                0: begin
                    r = $urandom_range(0, 2);
                    rs = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
                    do_op(1'($urandom_range(0, 1)), rs, 1'b0, 3'($urandom_range(0, 7)),
                          $urandom(), $urandom(), $urandom(), 5'($urandom_range(0, 31)), 0, 32'h0);
                end
                1: begin
                    f3 = 3'(f3_ld[$urandom_range(0, 4)]);
                    do_op(1'b1, 2'b01, 1'b0, f3, $urandom(), $urandom(), $urandom(),
                          5'($urandom_range(0, 31)), int'(wn), $urandom());
                end
                default: begin
                    f3 = 3'($urandom_range(0, 2));
                    do_op(1'($urandom_range(0, 1)), 2'b00, 1'b1, f3, $urandom(), $urandom(),
                          $urandom(), 5'($urandom_range(0, 31)), int'(wn), $urandom());
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-stage unit that consumes the Execute→Memory pipeline register outputs: RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM and RdM.
- Performs loads and stores over a req/ack data-memory bus and drives Stall back to Execute and earlier stages while an access is outstanding.
- Holds the Memory→Writeback pipeline register and produces ResultW for writeback and forwarding.

Parameters:
- ADDR_WIDTH, 32, width of dmem_addr; the low ADDR_WIDTH bits of ALUResultM are used.
- MAX_WAIT, 16, maximum REQ cycles without dmem_ack before the access is aborted with a bus error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWriteM  in  1  register-write enable of the instruction in M.
- ResultSrcM  in  2  00 = ALU, 01 = load data, 10 = PC+4, 11 = ALU; a value of 01 marks a load.
- MemWriteM  in  1  store enable.
- Funct3M  in  3  access size and sign: 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- ALUResultM  in  32  effective address or ALU result.
- WriteDataM  in  32  store data.
- RdM  in  5  destination register.
- PCPlus4M  in  32  link value.
- StallM  out  1  freezes Execute and earlier stages (drives their Stall input).
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- dmem_be  out  4  byte lane enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_ack  in  1  access complete; rdata is valid in the same cycle.
- dmem_rdata  in  32  read word.
- RegWriteW, ResultSrcW[2], ALUResultW[32], ReadDataW[32], RdW[5], PCPlus4W[32]  out  Writeback pipeline register outputs.
- ResultW  out  32  ResultSrcW-selected writeback value.
- BusErrW  out  1  the instruction now in W timed out.

Behaviour:
- A memory op is present when MemWriteM = 1 or ResultSrcM = 01.
- FSM states: IDLE, REQ, DONE.

IDLE:
- No memory op: StallM = 0; the W register loads from the M inputs on every edge (1-cycle latency).
- Memory op: StallM = 1 combinationally. dmem_req/we/addr/be/wdata are registered and asserted from the next cycle. Next state is REQ.

REQ:
- StallM = 1. dmem_req = 1 and all bus outputs are held stable until dmem_ack.
- On ack: for a load, capture the extracted data into an internal holding register; next state DONE.
- Wait counter: cleared on entry to REQ and incremented each REQ cycle without ack.
- When the counter reaches MAX_WAIT: drop dmem_req, set an internal error flag, next state DONE.

DONE:
- StallM = 0; the W register loads with the held data and BusErrW = flag; next state IDLE.
- Minimum memory-op latency is 3 cycles (zero-wait ack). Each extra cycle before ack adds 1.

While StallM = 1:
- The W register loads a bubble: RegWriteW = 0, BusErrW = 0, other W fields hold their values.

Byte lanes, using offset = ALUResultM[1:0]:
- B: be = 0001 << offset.
- H: be = 0011 << (offset[1] × 2).
- W: be = 1111.
- Store data: wdata = the WriteDataM byte or half replicated across all lanes.
- Load data: select the byte/half from dmem_rdata by offset. B and H sign-extend; BU and HU zero-extend.

Misaligned access (H with offset[0] = 1, or W with offset ≠ 0), default behaviour:
- The low address bits are ignored: H uses offset[1], W uses lane 0.

Other rules:
- dmem_ack in IDLE or DONE is ignored.
- Reset, including mid-access: FSM = IDLE, dmem_req = 0, dmem_we = 0, dmem_be = 0, dmem_addr = 0, dmem_wdata = 0, StallM = 0, all W outputs = 0, BusErrW = 0, counter = 0. A pending access is abandoned and never retried.
- ResultW is combinational from the W register: 01 → ReadDataW, 10 → PCPlus4W, otherwise ALUResultW.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no bus request. IDLE goes directly to DONE (2-cycle latency), RegWriteW is forced to 0, and an extra output MisalignW = 1 is shown for that W instruction.
- Undefined: MisalignW does not exist, and misaligned accesses follow the default rule above.

Test Plan:
- ALU op (RegWriteM = 1, RdM = 5, ALUResultM = 0x1234, ResultSrcM = 00) → next edge RdW = 5, ResultW = 0x1234, StallM stays 0, dmem_req never rises.
- LB at 0x103, ack on the first REQ cycle with rdata = 0x80AABBCC → StallM high for 2 cycles; in DONE be = 1000; then ResultW = 0xFFFFFF80, RegWriteW = 1.
- SH at 0x102, WriteDataM = 0x0000BEEF, ack after 3 wait cycles → dmem_we = 1, be = 1100, wdata = 0xBEEFBEEF held for 4 cycles, StallM high for 5 cycles, W-register bubbles (RegWriteW = 0) during the stall.
- LW with no ack, MAX_WAIT = 16 → dmem_req drops after 16 REQ cycles, BusErrW = 1 for one cycle, StallM then 0.
- rst asserted during REQ → dmem_req and StallM go 0 immediately (asynchronous); after release an ALU op passes in 1 cycle.
- With MISALIGN_TRAP_EN defined, LW at 0x101 → no dmem_req, MisalignW = 1, RegWriteW = 0 after 2 cycles.
